// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
//   Shared definitions for the audio playback path: default sample width and
//   FIFO depth, the left/right sample pair layout, the LRCK level that marks
//   the left channel, and helpers that classify LRCK transitions.
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int FIFO_DEPTH_DEFAULT = 128;

    // Codec is configured so that LRCK high carries the left channel.
    localparam logic LRCK_LEFT_LEVEL = 1'b1;

    // Pair layout as stored in the FIFO: left in the upper half.
    typedef struct packed {
        logic [DATA_WIDTH_DEFAULT-1:0] left;
        logic [DATA_WIDTH_DEFAULT-1:0] right;
    } sample_pair_t;

    // True when LRCK just entered the left-channel level.
    function automatic logic is_left_start(input logic cur, input logic prev);
        return (cur == LRCK_LEFT_LEVEL) && (prev != LRCK_LEFT_LEVEL);
    endfunction

    // True when LRCK just left the left-channel level.
    function automatic logic is_right_start(input logic cur, input logic prev);
        return (cur != LRCK_LEFT_LEVEL) && (prev == LRCK_LEFT_LEVEL);
    endfunction

endpackage

// File: rtl/audio_out_fifo.sv
// -----------------------------------------------------------------------------
// audio_out_fifo
//   Single-clock FIFO of sample pairs. Occupancy is tracked as a free-slot
//   count so full and empty never depend on pointer comparison.
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   clear        synchronous flush, beats push and pop
//   push/wr_data store a pair when not full (writes while full are ignored)
//   pop/rd_data  rd_data shows the oldest pair; pop discards it when non-empty
//   space        registered free-slot count, 0..DEPTH
//   not_full     registered, 1 when at least one slot is free
//   empty        1 when no pair is stored
// -----------------------------------------------------------------------------
module audio_out_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 128,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] space,
    output logic             not_full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] space_r;
    logic [CNT_W-1:0] space_next_s;
    logic             not_full_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (space_r == CNT_W'(DEPTH));
    assign push_ok_s = push & not_full_r & ~clear;
    assign pop_ok_s  = pop & ~empty & ~clear;
    assign rd_data   = mem_r[rd_ptr_r];
    assign space     = space_r;
    assign not_full  = not_full_r;

    // Next free-slot count: push and pop together leave it unchanged.
    always_comb begin
        space_next_s = space_r;
        if (clear) begin
            space_next_s = CNT_W'(DEPTH);
        end else if (push_ok_s && !pop_ok_s) begin
            space_next_s = space_r - CNT_W'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            space_next_s = space_r + CNT_W'(1);
        end else begin
            space_next_s = space_r;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers (wrap naturally at power-of-two depth) and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            space_r    <= CNT_W'(DEPTH);
            not_full_r <= 1'b1;
        end else begin
            if (clear) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (push_ok_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_ok_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
            space_r    <= space_next_s;
            not_full_r <= (space_next_s != {CNT_W{1'b0}});
        end
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// audio_dac_serializer
//   Playback side of the audio controller. User logic queues left/right
//   pairs; each codec frame (LRCK rise = left, fall = right) one pair is
//   shifted out MSB first on AUD_DACDAT, updated on BCLK falling edges.
//   The codec is clock master; BCLK and LRCK are resynchronised to CLOCK_50.
// Ports
//   CLOCK_50                 system clock
//   reset                    asynchronous active-high reset
//   clear_audio_out_memory   synchronous flush of FIFO and shifter
//   left/right_channel_audio_out, write_audio_out   pair push interface
//   AUD_BCLK, AUD_DACLRCK    codec bit and frame clocks
//   audio_out_allowed        registered, 1 while the FIFO has a free slot
//   fifo_write_space         registered free-slot count
//   underrun                 one-cycle pulse: left frame began with FIFO empty
//   AUD_DACDAT               serial DAC data
// -----------------------------------------------------------------------------
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  clear_audio_out_memory,
    input  logic [DATA_WIDTH-1:0] left_channel_audio_out,
    input  logic [DATA_WIDTH-1:0] right_channel_audio_out,
    input  logic                  write_audio_out,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  audio_out_allowed,
    output logic [CNT_W-1:0]      fifo_write_space,
    output logic                  underrun,
    output logic                  AUD_DACDAT
);

    logic [2:0]            bclk_sync_r;
    logic [2:0]            lrck_sync_r;
    logic [1:0]            warm_r;
    logic                  edges_valid_s;
    logic                  bclk_fall_s;
    logic                  left_start_s;
    logic                  right_start_s;

    logic [2*DATA_WIDTH-1:0] fifo_rd_data_s;
    logic                    fifo_empty_s;
    logic                    pop_s;
    logic [DATA_WIDTH-1:0]   pop_left_s;
    logic [DATA_WIDTH-1:0]   pop_right_s;

    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] hold_r;
    logic                  dacdat_r;
    logic                  underrun_r;
    logic [DATA_WIDTH-1:0] shift_base_s;
    logic [DATA_WIDTH-1:0] shift_next_s;
    logic [DATA_WIDTH-1:0] hold_next_s;
    logic                  dacdat_next_s;
    logic                  underrun_next_s;

    // Two-flop synchronisers plus one history flop for the codec clocks.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            bclk_sync_r <= 3'b000;
            lrck_sync_r <= 3'b000;
        end else begin
            bclk_sync_r <= {bclk_sync_r[1:0], AUD_BCLK};
            lrck_sync_r <= {lrck_sync_r[1:0], AUD_DACLRCK};
        end
    end

    // Edges are ignored until all three flops hold real pin samples, so a
    // reset released mid-frame cannot fake an LRCK edge and start mid-word.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            warm_r <= 2'd0;
        end else if (warm_r != 2'd3) begin
            warm_r <= warm_r + 2'd1;
        end else begin
            warm_r <= warm_r;
        end
    end

    assign edges_valid_s = (warm_r == 2'd3);
    assign bclk_fall_s   = edges_valid_s & bclk_sync_r[2] & ~bclk_sync_r[1];
    assign left_start_s  = edges_valid_s & is_left_start(lrck_sync_r[1], lrck_sync_r[2]);
    assign right_start_s = edges_valid_s & is_right_start(lrck_sync_r[1], lrck_sync_r[2]);

    assign pop_s       = left_start_s & ~fifo_empty_s & ~clear_audio_out_memory;
    assign pop_left_s  = fifo_rd_data_s[2*DATA_WIDTH-1:DATA_WIDTH];
    assign pop_right_s = fifo_rd_data_s[DATA_WIDTH-1:0];

    audio_out_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (CLOCK_50),
        .rst      (reset),
        .clear    (clear_audio_out_memory),
        .push     (write_audio_out),
        .wr_data  ({left_channel_audio_out, right_channel_audio_out}),
        .pop      (pop_s),
        .rd_data  (fifo_rd_data_s),
        .space    (fifo_write_space),
        .not_full (audio_out_allowed),
        .empty    (fifo_empty_s)
    );

    // Frame loads: the word to shift this cycle, before any BCLK shift.
    always_comb begin
        shift_base_s    = shift_r;
        hold_next_s     = hold_r;
        underrun_next_s = 1'b0;
        if (clear_audio_out_memory) begin
            shift_base_s = {DATA_WIDTH{1'b0}};
            hold_next_s  = {DATA_WIDTH{1'b0}};
        end else if (left_start_s) begin
            if (!fifo_empty_s) begin
                shift_base_s = pop_left_s;
                hold_next_s  = pop_right_s;
            end else begin
                shift_base_s    = {DATA_WIDTH{1'b0}};
                hold_next_s     = {DATA_WIDTH{1'b0}};
                underrun_next_s = 1'b1;
            end
        end else if (right_start_s) begin
            shift_base_s = hold_r;
            hold_next_s  = hold_r;
        end else begin
            shift_base_s = shift_r;
            hold_next_s  = hold_r;
        end
    end

    // Bit shifting: a load coinciding with a BCLK fall drives the new MSB
    // on that same fall; zero fill keeps the line low after the last bit.
    always_comb begin
        shift_next_s  = shift_base_s;
        dacdat_next_s = dacdat_r;
        if (clear_audio_out_memory) begin
            shift_next_s  = {DATA_WIDTH{1'b0}};
            dacdat_next_s = 1'b0;
        end else if (bclk_fall_s) begin
            shift_next_s  = {shift_base_s[DATA_WIDTH-2:0], 1'b0};
            dacdat_next_s = shift_base_s[DATA_WIDTH-1];
        end else begin
            shift_next_s  = shift_base_s;
            dacdat_next_s = dacdat_r;
        end
    end

    // Shifter, hold word, serial output and underrun pulse registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            shift_r    <= {DATA_WIDTH{1'b0}};
            hold_r     <= {DATA_WIDTH{1'b0}};
            dacdat_r   <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            shift_r    <= shift_next_s;
            hold_r     <= hold_next_s;
            dacdat_r   <= dacdat_next_s;
            underrun_r <= underrun_next_s;
        end
    end

    assign AUD_DACDAT = dacdat_r;
    assign underrun   = underrun_r;

endmodule
